// File: rtl/mtr_pkg.sv
// mtr_pkg: types and constants shared between the commutation block and
// the gate-drive stage (mtr_drv).
//   sel_t       - 2-bit phase mode encoding driven on selGrn/selYlw/selBlu
//   PWM_PERIOD  - clocks per PWM period
//   decode_req  - phase mode + PWM level -> {high_req, low_req}
package mtr_pkg;

  typedef enum logic [1:0] {
    HIGH_Z  = 2'b00,
    FORWARD = 2'b01,
    REVERSE = 2'b10,
    BRAKE   = 2'b11
  } sel_t;

  localparam int PWM_W      = 11;
  localparam int PWM_PERIOD = 2048;

  // Returns {high_req, low_req}. The two requests are never both 1.
  function automatic logic [1:0] decode_req(input sel_t sel, input logic pwm);
    logic [1:0] req;
    req = 2'b00;
    case (sel)
      HIGH_Z:  req = 2'b00;
      FORWARD: req = {pwm, ~pwm};
      REVERSE: req = {~pwm, pwm};
      BRAKE:   req = {1'b0, pwm};
      default: req = 2'b00;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/mtr_drv_nonoverlap.sv
// nonoverlap: dead-time insertion for one half-bridge leg.
//   clk, rst_n         - clock, async active-low reset
//   high_req, low_req  - requested gate states (never both 1)
//   high, low          - registered gate enables
// Any change in the request pair forces both gates off and restarts the
// dead counter; the new request reaches the gates DEADTIME clocks after
// the edge that saw the change. Turn-off is therefore immediate and
// turn-on is delayed.
module nonoverlap #(
  parameter int DEADTIME = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic high_req,
  input  logic low_req,
  output logic high,
  output logic low
);

  localparam logic [5:0] DT    = 6'(DEADTIME);
  localparam logic [5:0] DT_M1 = DT - 6'd1;

  logic       high_ff;
  logic       low_ff;
  logic [5:0] dead_cnt;
  logic       change;

  assign change = (high_req != high_ff) || (low_req != low_ff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_ff  <= 1'b0;
      low_ff   <= 1'b0;
      dead_cnt <= 6'd0;
      high     <= 1'b0;
      low      <= 1'b0;
    end else begin
      high_ff <= high_req;
      low_ff  <= low_req;
      if (change) begin
        dead_cnt <= 6'd0;
        high     <= 1'b0;
        low      <= 1'b0;
      end else begin
        if (dead_cnt < DT) begin
          dead_cnt <= dead_cnt + 6'd1;
        end
        // Gates follow the request on the edge where the counter reaches
        // DEADTIME, so the off window is exactly DEADTIME clocks.
        if (dead_cnt >= DT_M1) begin
          high <= high_req;
          low  <= low_req;
        end else begin
          high <= 1'b0;
          low  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: three-phase gate-drive stage.
//   clk, rst_n              - clock, async active-low reset
//   duty[10:0]              - PWM on-time in clocks per 2048-clock period
//   selGrn/selYlw/selBlu    - per-phase mode (sel_t encoding)
//   high*/low*              - registered high-/low-side gate enables
// A free-running 11-bit counter generates one registered PWM level; duty is
// only taken at the period boundary so a period is never cut short. Each
// phase decodes its request from the PWM level and passes it through a
// dead-time leg.
module mtr_drv
  import mtr_pkg::*;
#(
  parameter int DEADTIME = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty,
  input  logic [1:0]       selGrn,
  input  logic [1:0]       selYlw,
  input  logic [1:0]       selBlu,
  output logic             highGrn,
  output logic             lowGrn,
  output logic             highYlw,
  output logic             lowYlw,
  output logic             highBlu,
  output logic             lowBlu
);

  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PWM_PERIOD - 1);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_ff;
  logic             pwm_sig;
  logic [1:0]       req_grn;
  logic [1:0]       req_ylw;
  logic [1:0]       req_blu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_ff <= '0;
      pwm_sig <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (pwm_cnt == CNT_LAST) begin
        duty_ff <= duty;
      end
      pwm_sig <= (pwm_cnt < duty_ff);
    end
  end

  assign req_grn = decode_req(sel_t'(selGrn), pwm_sig);
  assign req_ylw = decode_req(sel_t'(selYlw), pwm_sig);
  assign req_blu = decode_req(sel_t'(selBlu), pwm_sig);

  nonoverlap #(.DEADTIME(DEADTIME)) u_leg_grn (
    .clk      (clk),
    .rst_n    (rst_n),
    .high_req (req_grn[1]),
    .low_req  (req_grn[0]),
    .high     (highGrn),
    .low      (lowGrn)
  );

  nonoverlap #(.DEADTIME(DEADTIME)) u_leg_ylw (
    .clk      (clk),
    .rst_n    (rst_n),
    .high_req (req_ylw[1]),
    .low_req  (req_ylw[0]),
    .high     (highYlw),
    .low      (lowYlw)
  );

  nonoverlap #(.DEADTIME(DEADTIME)) u_leg_blu (
    .clk      (clk),
    .rst_n    (rst_n),
    .high_req (req_blu[1]),
    .low_req  (req_blu[0]),
    .high     (highBlu),
    .low      (lowBlu)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv. Stimulus pushes the expected gate pulse widths into a
// queue per gate; a monitor measures every completed high pulse on each
// gate and compares it with the head of that gate's queue. The monitor
// also checks high/low exclusivity on every leg each cycle.
module tb_mtr_drv;
  import mtr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] duty = '0;
  logic [1:0]  selGrn = 2'b00;
  logic [1:0]  selYlw = 2'b00;
  logic [1:0]  selBlu = 2'b00;
  logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu;

  mtr_drv #(.DEADTIME(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty    (duty),
    .selGrn  (selGrn),
    .selYlw  (selYlw),
    .selBlu  (selBlu),
    .highGrn (highGrn),
    .lowGrn  (lowGrn),
    .highYlw (highYlw),
    .lowYlw  (lowYlw),
    .highBlu (highBlu),
    .lowBlu  (lowBlu)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int expq [6][$];
  int width [6];

  // gate index: 0 highGrn, 1 lowGrn, 2 highYlw, 3 lowYlw, 4 highBlu, 5 lowBlu
  wire [5:0] gate = {lowBlu, highBlu, lowYlw, highYlw, lowGrn, highGrn};

  // cyc = number of rising edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int exp_w;
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (gate[2*l] && gate[2*l+1]) begin
        errors++;
        $display("FAIL overlap_leg%0d got high=1 low=1 want not both (cyc %0d)", l, cyc);
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (!rst_n || !mon_en) begin
        width[i] = 0;
      end else if (gate[i]) begin
        width[i]++;
      end else if (width[i] > 0) begin
        checks++;
        if (expq[i].size() == 0) begin
          errors++;
          $display("FAIL width_g%0d got pulse %0d want none (cyc %0d)", i, width[i], cyc);
        end else begin
          exp_w = expq[i].pop_front();
          if (exp_w != width[i]) begin
            errors++;
            $display("FAIL width_g%0d got %0d want %0d (cyc %0d)", i, width[i], exp_w, cyc);
          end
        end
        width[i] = 0;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset(input logic [10:0] d, input logic [1:0] g,
                          input logic [1:0] y, input logic [1:0] b);
    rst_n  = 1'b0;
    duty   = d;
    selGrn = g;
    selYlw = y;
    selBlu = b;
    for (int i = 0; i < 6; i++) expq[i].delete();
    repeat (3) @(negedge clk);
    check("reset_gates", int'(gate), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (expq[i].size() != 0) begin
        errors++;
        $display("FAIL %s_g%0d got %0d pulses outstanding want 0", name, i, expq[i].size());
      end
    end
  endtask

  initial begin
    // A: duty 0x400, Grn FORWARD; then async reset with gates active
    do_reset(11'h400, FORWARD, HIGH_Z, HIGH_Z);
    mon_en = 1'b1;
    expq[0] = '{992, 992, 992};
    expq[1] = '{2017, 992, 992, 992};
    wait_cyc(32);
    check("a_low_dead", int'(lowGrn), 0);
    wait_cyc(33);
    check("a_low_on", int'(lowGrn), 1);
    wait_cyc(2048*4 + 100);
    check("a_high_active", int'(highGrn), 1);
    check_drained("a_drain");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_rst_gates", int'(gate), 0);

    // B: duty 0, FORWARD -> low constantly on, high never
    do_reset(11'h000, FORWARD, HIGH_Z, HIGH_Z);
    wait_cyc(32);
    check("b_low_dead", int'(lowGrn), 0);
    wait_cyc(33);
    check("b_low_on", int'(lowGrn), 1);
    wait_cyc(2048*2 + 500);
    check("b_low_still", int'(lowGrn), 1);
    check("b_high_off", int'(highGrn), 0);
    check_drained("b_drain");

    // C: all BRAKE, duty 0x600
    do_reset(11'h600, BRAKE, BRAKE, BRAKE);
    expq[1] = '{1504, 1504, 1504};
    expq[3] = '{1504, 1504, 1504};
    expq[5] = '{1504, 1504, 1504};
    wait_cyc(2048*4 + 100);
    check_drained("c_drain");

    // D: duty 0x400 -> 0x200 at pwm_cnt 100 of the second period
    do_reset(11'h400, FORWARD, HIGH_Z, HIGH_Z);
    expq[0] = '{992, 480};
    expq[1] = '{2017, 992, 1504};
    wait_cyc(2048 + 100);
    duty = 11'h200;
    wait_cyc(6300);
    check_drained("d_drain");

    // E: Ylw FORWARD -> REVERSE while highYlw is on
    do_reset(11'h400, HIGH_Z, FORWARD, HIGH_Z);
    expq[2] = '{419, 992, 992};
    expq[3] = '{2017, 541, 992};
    wait_cyc(2500);
    check("e_high_before", int'(highYlw), 1);
    selYlw = REVERSE;
    wait_cyc(2501);
    check("e_high_drop", int'(highYlw), 0);
    check("e_low_dead0", int'(lowYlw), 0);
    wait_cyc(2532);
    check("e_low_dead31", int'(lowYlw), 0);
    wait_cyc(2533);
    check("e_low_on", int'(lowYlw), 1);
    wait_cyc(6200);
    check_drained("e_drain");

    // F: random sel/duty for 10 periods, exclusivity checked by the monitor
    mon_en = 1'b0;
    do_reset(11'($urandom_range(0, 2047)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    while (cyc < 2048*10) begin
      repeat ($urandom_range(1, 300)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: selGrn = 2'($urandom_range(0, 3));
        1: selYlw = 2'($urandom_range(0, 3));
        2: selBlu = 2'($urandom_range(0, 3));
        default: duty = 11'($urandom_range(0, 2047));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
